// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU pixel-engine memory path: SRAM map,
// requester indices and the SRAM port arbiter state encoding.
package gpu_mem_pkg;

    localparam int LAYER1_BASE = 0;
    localparam int LAYER2_BASE = 65536;
    localparam int TEX1_BASE   = 131072;
    localparam int TEX2_BASE   = 135168;
    localparam int TEX3_BASE   = 139264;
    localparam int OUT_BASE    = 143360;
    localparam int LINE_STRIDE = 64;

    localparam int REQ_RASTER  = 0;
    localparam int REQ_TEXTURE = 1;
    localparam int REQ_ALPHA   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the shared SRAM port.
// The slave view belongs to the arbiter; the master view to engines plus SRAM.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_SIZE_BITS = 24,
    parameter int DW             = 1536
);
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                req_read_enable;
    logic [NUM_REQ-1:0]                req_write_enable;
    logic [NUM_REQ*ADDR_SIZE_BITS-1:0] req_address;
    logic [NUM_REQ*DW-1:0]             req_write_data;
    logic [NUM_REQ-1:0]                gnt;
    logic [NUM_REQ-1:0]                rd_valid;
    logic [DW-1:0]                     read_data_out;
    logic                              read_enable;
    logic                              write_enable;
    logic [ADDR_SIZE_BITS-1:0]         address;
    logic [DW-1:0]                     write_data;
    logic [DW-1:0]                     read_data;
    logic                              proto_err;

    modport slave (
        input  req, req_read_enable, req_write_enable, req_address, req_write_data, read_data,
        output gnt, rd_valid, read_data_out, read_enable, write_enable, address, write_data, proto_err
    );

    modport master (
        output req, req_read_enable, req_write_enable, req_address, req_write_data, read_data,
        input  gnt, rd_valid, read_data_out, read_enable, write_enable, address, write_data, proto_err
    );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping modulo
// NUM_REQ. Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx
);

    logic found;

    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        found         = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found            = 1'b1;
                winner_onehot[j] = 1'b1;
                winner_idx       = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port among the pixel engines: round-robin grant held while
// the owner keeps req high, one dead cycle between owners, sticky protocol flag.
module sram_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int NUM_REQ         = 3
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  bus
);

    localparam int DW    = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  rd_valid_q;
    logic                proto_err_q;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                fwd_active;
    logic                owner_rd;
    logic                owner_wr;
    logic                err_now;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req           (bus.req),
        .ptr           (ptr_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx)
    );

    // gnt_q is nonzero only in GRANT, so it doubles as the owner mask for
    // spotting strobes from anyone who does not hold the port.
    always_comb begin
        fwd_active = (state_q == GRANT) && bus.req[owner_q];
        owner_rd   = fwd_active && bus.req_read_enable[owner_q];
        owner_wr   = fwd_active && bus.req_write_enable[owner_q];
        err_now    = (|((bus.req_read_enable | bus.req_write_enable) & ~gnt_q))
                     || (owner_rd && owner_wr);
    end

    assign bus.read_enable   = owner_rd;
    assign bus.write_enable  = owner_wr && !owner_rd;
    assign bus.address       = fwd_active ? bus.req_address[int'(owner_q)*ADDR_SIZE_BITS +: ADDR_SIZE_BITS] : '0;
    assign bus.write_data    = fwd_active ? bus.req_write_data[int'(owner_q)*DW +: DW] : '0;
    assign bus.read_data_out = bus.read_data;
    assign bus.gnt           = gnt_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.proto_err     = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rd_valid_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_valid_q  <= owner_rd ? gnt_q : '0;
            proto_err_q <= proto_err_q || err_now;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q <= GRANT;
                        owner_q <= pick_idx;
                        gnt_q   <= pick_onehot;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner_q]) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                        ptr_q   <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: single owner, contention order,
// pointer wrap, protocol violations and reset in the middle of a write.
module tb_sram_port_arbiter;
    import gpu_mem_pkg::*;

    localparam int NR = 3;
    localparam int AW = 24;
    localparam int DW = 1536;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] wpat;
    logic [DW-1:0] rpat;
    logic [2:0]    req_v;

    sram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_SIZE_BITS(AW), .DW(DW)) bus ();

    sram_port_arbiter #(
        .ADDR_SIZE_BITS  (AW),
        .WORD_SIZE_BYTES (3),
        .DATA_SIZE_WORDS (64),
        .NUM_REQ         (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] rd, input logic [2:0] wr);
        bus.req              = r;
        bus.req_read_enable  = rd;
        bus.req_write_enable = wr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        wpat = {24{64'h0123_4567_89AB_CDEF}};
        wpat[DW-1 -: 64] = 64'hDEAD_BEEF_CAFE_F00D;
        rpat = {24{64'h1111_2222_3333_4444}};
        rpat[63:0] = 64'h5A5A_0F0F_C3C3_9696;

        bus.req_address    = '0;
        bus.req_write_data = '0;
        bus.read_data      = '0;
        apply_stimulus(3'b000, 3'b000, 3'b000);

        tick();
        tick();
        check_output("rst_gnt",       64'(bus.gnt),          64'h0);
        check_output("rst_rd_valid",  64'(bus.rd_valid),     64'h0);
        check_output("rst_proto_err", 64'(bus.proto_err),    64'h0);
        check_output("rst_re_we",     64'({bus.read_enable, bus.write_enable}), 64'h0);
        check_output("rst_address",   64'(bus.address),      64'h0);
        rst = 1'b0;

        // single requester: alpha blender reads then writes the output line
        apply_stimulus(3'b100, 3'b000, 3'b000);
        tick();
        check_output("single_gnt", 64'(bus.gnt), 64'h4);
        bus.req_address[REQ_ALPHA*AW +: AW] = 24'(OUT_BASE);
        apply_stimulus(3'b100, 3'b100, 3'b000);
        check_output("single_re",      64'(bus.read_enable),  64'h1);
        check_output("single_we_idle", 64'(bus.write_enable), 64'h0);
        check_output("single_addr",    64'(bus.address),      64'd143360);
        check_output("single_rdv_pre", 64'(bus.rd_valid),     64'h0);
        bus.read_data = rpat;
        tick();
        apply_stimulus(3'b100, 3'b000, 3'b000);
        check_output("single_rdv",   64'(bus.rd_valid),          64'h4);
        check_output("single_rdata", bus.read_data_out[63:0],    64'h5A5A_0F0F_C3C3_9696);
        tick();
        check_output("single_rdv_clr", 64'(bus.rd_valid), 64'h0);
        bus.req_address[REQ_ALPHA*AW +: AW]  = 24'(OUT_BASE + LINE_STRIDE);
        bus.req_write_data[REQ_ALPHA*DW +: DW] = wpat;
        apply_stimulus(3'b100, 3'b000, 3'b100);
        check_output("wr1_we",    64'(bus.write_enable),     64'h1);
        check_output("wr1_re",    64'(bus.read_enable),      64'h0);
        check_output("wr1_addr",  64'(bus.address),          64'd143424);
        check_output("wr1_lo",    bus.write_data[63:0],      64'h0123_4567_89AB_CDEF);
        check_output("wr1_hi",    bus.write_data[DW-1 -: 64], 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check_output("wr2_we",    64'(bus.write_enable),     64'h1);
        check_output("wr2_hi",    bus.write_data[DW-1 -: 64], 64'hDEAD_BEEF_CAFE_F00D);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        check_output("drop_addr", 64'(bus.address), 64'h0);
        check_output("drop_wd",   bus.write_data[63:0], 64'h0);
        tick();
        check_output("rel_gnt",  64'(bus.gnt), 64'h0);
        tick();
        check_output("dead_gnt", 64'(bus.gnt), 64'h0);
        check_output("single_no_err", 64'(bus.proto_err), 64'h0);

        // contention: all three ask at once, each holds for 4 cycles
        req_v = 3'b111;
        apply_stimulus(req_v, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output($sformatf("cont_gnt%0d", k), 64'(bus.gnt), 64'(3'b001 << k));
            repeat (3) begin
                tick();
                check_output($sformatf("cont_hold%0d", k), 64'(bus.gnt), 64'(3'b001 << k));
            end
            req_v[k] = 1'b0;
            apply_stimulus(req_v, 3'b000, 3'b000);
            tick();
            check_output($sformatf("cont_gap_a%0d", k), 64'(bus.gnt), 64'h0);
            tick();
            check_output($sformatf("cont_gap_b%0d", k), 64'(bus.gnt), 64'h0);
        end

        // pointer wrap: release texture so ptr=2, then 3'b011 serves 0 then 1
        apply_stimulus(3'b010, 3'b000, 3'b000);
        tick();
        check_output("wrap_pre_gnt", 64'(bus.gnt), 64'h2);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        tick();
        tick();
        apply_stimulus(3'b011, 3'b000, 3'b000);
        tick();
        check_output("wrap_first", 64'(bus.gnt), 64'h1);
        apply_stimulus(3'b010, 3'b000, 3'b000);
        tick();
        tick();
        tick();
        check_output("wrap_second", 64'(bus.gnt), 64'h2);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        tick();
        tick();

        // violation: texture strobes a write while raster owns the port
        apply_stimulus(3'b001, 3'b000, 3'b000);
        tick();
        check_output("viol_gnt",     64'(bus.gnt),       64'h1);
        check_output("viol_err_pre", 64'(bus.proto_err), 64'h0);
        apply_stimulus(3'b001, 3'b000, 3'b010);
        check_output("viol_we_blocked", 64'(bus.write_enable), 64'h0);
        tick();
        check_output("viol_err", 64'(bus.proto_err), 64'h1);
        apply_stimulus(3'b001, 3'b000, 3'b000);
        tick();
        check_output("viol_err_sticky", 64'(bus.proto_err), 64'h1);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        tick();
        tick();
        check_output("viol_err_idle", 64'(bus.proto_err), 64'h1);

        // reset in the middle of an alpha write
        apply_stimulus(3'b100, 3'b000, 3'b000);
        tick();
        check_output("mid_gnt", 64'(bus.gnt), 64'h4);
        apply_stimulus(3'b100, 3'b000, 3'b100);
        check_output("mid_we", 64'(bus.write_enable), 64'h1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_gnt",   64'(bus.gnt),          64'h0);
        check_output("mid_rst_we",    64'(bus.write_enable), 64'h0);
        check_output("mid_rst_rdv",   64'(bus.rd_valid),     64'h0);
        check_output("mid_rst_err",   64'(bus.proto_err),    64'h0);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        tick();
        rst = 1'b0;
        apply_stimulus(3'b101, 3'b000, 3'b000);
        tick();
        check_output("post_rst_gnt", 64'(bus.gnt), 64'h1);

        // owner strobes read and write together: read wins, flag set
        apply_stimulus(3'b101, 3'b001, 3'b001);
        check_output("both_re", 64'(bus.read_enable),  64'h1);
        check_output("both_we", 64'(bus.write_enable), 64'h0);
        tick();
        apply_stimulus(3'b101, 3'b000, 3'b000);
        check_output("both_err", 64'(bus.proto_err), 64'h1);
        check_output("both_rdv", 64'(bus.rd_valid),  64'h1);
        apply_stimulus(3'b000, 3'b000, 3'b000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM port (24-bit address, 1536-bit line) between the GPU's pixel engines: layer rasteriser, texture loader, alpha blender. Each requester raises `req`, waits for its one-hot `gnt`, then runs its own read/write sequence exactly as on a private port. The requester keeps the port until it drops `req`. Arbitration is round-robin with one dead cycle between owners. The block sits between the engines and the SRAM controller.

## Interface
- `ADDR_SIZE_BITS`, 24: SRAM address width.
- `WORD_SIZE_BYTES`, 3: bytes per pixel word.
- `DATA_SIZE_WORDS`, 64: words per SRAM line. Line width is DW = WORD_SIZE_BYTES·DATA_SIZE_WORDS·8 = 1536.
- `NUM_REQ`, 3: number of requesters, 2..8. Requester i occupies slice i of every packed bus.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req`  in  NUM_REQ  request/hold, one bit per requester.
- `req_read_enable`  in  NUM_REQ  per-requester read strobe.
- `req_write_enable`  in  NUM_REQ  per-requester write strobe.
- `req_address`  in  NUM_REQ·ADDR_SIZE_BITS  packed addresses.
- `req_write_data`  in  NUM_REQ·DW  packed write data.
- `gnt`  out  NUM_REQ  one-hot grant, registered.
- `rd_valid`  out  NUM_REQ  one-hot; marks the cycle in which `read_data` belongs to that requester.
- `read_data_out`  out  DW  broadcast of `read_data`.
- `read_enable`, `write_enable`  out  1 each  to SRAM.
- `address`  out  ADDR_SIZE_BITS  to SRAM.
- `write_data`  out  DW  to SRAM.
- `read_data`  in  DW  from SRAM. Valid the cycle after `read_enable`.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- FSM states:
  - IDLE → GRANT when any `req` is set. The winner is the first set bit searching from `ptr` upward, modulo NUM_REQ. `gnt` is the registered one-hot of the winner.
  - GRANT → RELEASE when `req[owner]` = 0. `gnt` clears on that edge, and `ptr` ← (owner+1) mod NUM_REQ.
  - RELEASE → IDLE unconditionally. This is the dead cycle; no grant is issued in it.
- Forwarding is combinational. It applies only while state = GRANT and `req[owner]` = 1: SRAM `read_enable`, `write_enable`, `address` and `write_data` equal the owner's slices. Otherwise all four outputs are 0.
- `rd_valid[owner]` is a register, set the cycle after a forwarded `read_enable`.
- `read_data_out` = `read_data` at all times.
- `proto_err` is set (and stays set until reset) on either condition:
  - any non-owner asserts a read or write strobe;
  - a forwarded access has `read_enable` and `write_enable` both high. In that case `write_enable` is suppressed and the read proceeds.
- A non-owner's `req` is never dropped by the arbiter. Requesters wait indefinitely.

## Timing
- Reset values: `gnt` = 0, `rd_valid` = 0, `proto_err` = 0, `ptr` = 0, state IDLE. All SRAM-side outputs are 0.
- Grant latency:
  - `req` rising at edge N, with state IDLE → `gnt` high after edge N+1.
  - First forwarded access is possible in cycle N+1.
- Release:
  - `req` low sampled at edge M → `gnt` low after M; RELEASE in cycle M..M+1; IDLE at M+1.
  - Earliest next `gnt` is after edge M+2, so there are 2 idle cycles between owners.
- Read: strobe in cycle K → `rd_valid` and `read_data` valid in cycle K+1, including when `req` drops in cycle K+1.
- Writes: multi-cycle writes (strobe held two cycles) pass through unchanged.
- Simultaneous requests: round-robin from `ptr`. Example with NUM_REQ = 3, `ptr` = 1, `req` = 3'b101 → requester 2 wins.
- Reset mid-grant: `gnt` drops asynchronously, the in-flight access is abandoned, and `ptr` returns to 0.

## Structure
- Shared package `gpu_mem_pkg`:
  - SRAM map constants: LAYER1_BASE 0, LAYER2_BASE 65536, TEX1_BASE 131072, TEX2_BASE 135168, TEX3_BASE 139264, OUT_BASE 143360, LINE_STRIDE 64.
  - Requester index constants: REQ_RASTER 0, REQ_TEXTURE 1, REQ_ALPHA 2.
  - Arbiter state enum (IDLE/GRANT/RELEASE).
- One sub-module: `rr_pick`. Combinational. Inputs `req` and `ptr`; outputs a one-hot winner and the winner index.

## Test plan
- Single requester: `req`=3'b100 at cycle 1 → `gnt`=3'b100 from cycle 2. Requester reads address 143360 → SRAM `address`=143360 and `read_enable`=1 in the same cycle. `rd_valid`=3'b100 in the next cycle.
- Contention: `req`=3'b111 from reset → grants arrive in the order 001, 010, 100. Each owner holds the grant for 4 cycles. There is a 2-cycle gap of `gnt`=0 between owners.
- Fairness wrap: `ptr`=2, `req`=3'b011 → requester 0 is granted first, then requester 1.
- Violation: requester 1 pulses `req_write_enable` while requester 0 owns the port → SRAM `write_enable` stays 0 and `proto_err`=1 until `rst`.
- Reset mid-operation: assert `rst` during a write owned by requester 2 → `gnt`, `write_enable`, `rd_valid` and `proto_err` all go to 0 immediately. After release, `req`=3'b101 grants requester 0.
